// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: MD op encoding, FSM state
// type and small op-classification helpers used by the unit and its controller.
package md_pkg;

   typedef logic [2:0] md_op_t;

   localparam md_op_t MD_MFLO  = 3'd0;
   localparam md_op_t MD_MULTU = 3'd1;
   localparam md_op_t MD_MULT  = 3'd2;
   localparam md_op_t MD_DIVU  = 3'd3;
   localparam md_op_t MD_DIV   = 3'd4;
   localparam md_op_t MD_MTLO  = 3'd5;
   localparam md_op_t MD_MTHI  = 3'd6;
   localparam md_op_t MD_MFHI  = 3'd7;

   localparam int CNT_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_e;

   function automatic logic is_mul_op(md_op_t op);
      return (op == MD_MULTU) || (op == MD_MULT);
   endfunction

   function automatic logic is_div_op(md_op_t op);
      return (op == MD_DIVU) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/md_if.sv
// Issue/result bundle between the execute-stage controller (master) and the
// multiply/divide unit (slave).
interface md_if #(
   parameter int WIDTH = 32
);
   import md_pkg::*;

   logic             start;
   md_op_t           md_op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, md_op, a, b, flush,
      input  busy, result, hi, lo
   );

   modport slave (
      input  start, md_op, a, b, flush,
      output busy, result, hi, lo
   );

endinterface

// File: rtl/md_arith.sv
// Combinational HI/LO computation for multu/mult/divu/div, including the
// divide-by-zero and most-negative / -1 overflow results.
module md_arith
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  md_op_t           op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   logic [2*WIDTH-1:0]        prod_u;
   logic signed [2*WIDTH-1:0] prod_s;
   logic                      b_zero;
   logic                      div_ovf;
   logic [WIDTH-1:0]          safe_bu;
   logic [WIDTH-1:0]          safe_bs;
   logic [WIDTH-1:0]          quot_u;
   logic [WIDTH-1:0]          rem_u;
   logic signed [WIDTH-1:0]   quot_s;
   logic signed [WIDTH-1:0]   rem_s;

   assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
   assign prod_s = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i})
                 * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});

   // Divisors that would give X or overflow are swapped for 1; the special
   // results for those cases are selected below.
   assign b_zero  = (b_i == '0);
   assign div_ovf = (a_i == MOST_NEG) && (b_i == '1);
   assign safe_bu = b_zero ? ONE : b_i;
   assign safe_bs = (b_zero || div_ovf) ? ONE : b_i;

   assign quot_u = a_i / safe_bu;
   assign rem_u  = a_i % safe_bu;
   assign quot_s = $signed(a_i) / $signed(safe_bs);
   assign rem_s  = $signed(a_i) % $signed(safe_bs);

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      hi_o = '0;
      lo_o = '0;
      case (op_i)
         MD_MULTU: begin
            hi_o = prod_u[2*WIDTH-1:WIDTH];
            lo_o = prod_u[WIDTH-1:0];
         end
         MD_MULT: begin
            hi_o = prod_s[2*WIDTH-1:WIDTH];
            lo_o = prod_s[WIDTH-1:0];
         end
         MD_DIVU: begin
            hi_o = b_zero ? a_i : rem_u;
            lo_o = b_zero ? '1  : quot_u;
         end
         MD_DIV: begin
            if (b_zero) begin
               hi_o = a_i;
               lo_o = '1;
            end else if (div_ovf) begin
               hi_o = '0;
               lo_o = MOST_NEG;
            end else begin
               hi_o = rem_s;
               lo_o = quot_s;
            end
         end
         default: begin
            hi_o = '0;
            lo_o = '0;
         end
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO: results are computed at issue,
// held in pending registers, and committed after a fixed latency unless flushed.
module md_unit
   import md_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic clk,
   input logic rst_n,
   md_if.slave md
);

   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   md_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] pend_hi_q;
   logic [WIDTH-1:0] pend_lo_q;
   logic [WIDTH-1:0] pend_hi_d;
   logic [WIDTH-1:0] pend_lo_d;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   md_arith #(
      .WIDTH (WIDTH)
   ) u_arith (
      .op_i (md.md_op),
      .a_i  (md.a),
      .b_i  (md.b),
      .hi_o (pend_hi_d),
      .lo_o (pend_lo_d)
   );

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               // flush masks an issue arriving on the same edge
               if (md.start && !md.flush) begin
                  if (is_mul_op(md.md_op) || is_div_op(md.md_op)) begin
                     pend_hi_q <= pend_hi_d;
                     pend_lo_q <= pend_lo_d;
                     cnt_q     <= is_mul_op(md.md_op) ? MULT_CNT : DIV_CNT;
                     state_q   <= BUSY;
                  end else if (md.md_op == MD_MTLO) begin
                     lo_q <= md.a;
                  end else if (md.md_op == MD_MTHI) begin
                     hi_q <= md.a;
                  end
               end
            end
            BUSY: begin
               // start is ignored here; flush wins over a coincident commit
               if (md.flush) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else if (cnt_q == CNT_ONE) begin
                  hi_q    <= pend_hi_q;
                  lo_q    <= pend_lo_q;
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            default: begin
               cnt_q   <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign md.busy   = (state_q == BUSY);
   assign md.hi     = hi_q;
   assign md.lo     = lo_q;
   assign md.result = (md.md_op == MD_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a reference model pushes expected HI/LO at
// issue, and each completed operation pops and compares against the DUT.
module tb_md_unit;
   import md_pkg::*;

   localparam int W        = 32;
   localparam int MULT_N   = 5;
   localparam int DIV_N    = 10;
   localparam int MAX_WAIT = 300;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } hl_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   md_if #(.WIDTH(W)) bus ();

   md_unit #(
      .WIDTH       (W),
      .MULT_CYCLES (MULT_N),
      .DIV_CYCLES  (DIV_N)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .md    (bus)
   );

   hl_t exp_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic hl_t model(input md_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
      hl_t         r;
      longint      sa, sb, sq, sr;
      logic [63:0] p, qv, rv;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = '0;
      case (op)
         MD_MULTU: begin
            p = 64'(a) * 64'(b);
            r = p;
         end
         MD_MULT: begin
            p = sa * sb;
            r = p;
         end
         MD_DIVU: begin
            if (b == 0) r = {a, {W{1'b1}}};
            else        r = {a % b, a / b};
         end
         MD_DIV: begin
            if (b == 0) r = {a, {W{1'b1}}};
            else begin
               sq = sa / sb;
               sr = sa % sb;
               qv = sq;
               rv = sr;
               r  = {rv[W-1:0], qv[W-1:0]};
            end
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic issue(input md_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.md_op = op;
      bus.a     = a;
      bus.b     = b;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int n_exp, input int already);
      int  cnt;
      bit  done;
      hl_t e;
      cnt  = already;
      done = 1'b0;
      for (int i = 0; i < MAX_WAIT && !done; i++) begin
         @(negedge clk);
         if (bus.busy) cnt++;
         else          done = 1'b1;
      end
      if (!done) begin
         check({tag, "_timeout"}, bus.busy, 1'b0);
         return;
      end
      check({tag, "_busy_cycles"}, W'(cnt), W'(n_exp));
      if (exp_q.size() == 0) begin
         check({tag, "_scoreboard"}, W'(0), W'(1));
      end else begin
         e = exp_q.pop_front();
         check({tag, "_hi"}, bus.hi, e.hi);
         check({tag, "_lo"}, bus.lo, e.lo);
      end
   endtask

   task automatic run_md(input string tag, input md_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_q.push_back(model(op, a, b));
      issue(op, a, b);
      wait_done(tag, is_mul_op(op) ? MULT_N : DIV_N, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] hp, lp;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.md_op = MD_MFLO;
      bus.a     = '0;
      bus.b     = '0;
      rst_n     = 1'b1;

      // asynchronous reset, asserted while clk is low
      #12 rst_n = 1'b0;
      #1;
      check("rst_hi", bus.hi, '0);
      check("rst_lo", bus.lo, '0);
      check("rst_busy", W'(bus.busy), '0);
      @(negedge clk) rst_n = 1'b1;

      run_md("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'd2);
      bus.md_op = MD_MFHI;
      #1 check("mfhi_result", bus.result, 32'h0000_0001);
      bus.md_op = MD_MFLO;
      #1 check("mflo_result", bus.result, 32'hFFFF_FFFE);

      run_md("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2);
      run_md("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run_md("divu_zero", MD_DIVU, 32'h0000_1234, 32'd0);
      run_md("div_zero", MD_DIV, 32'h8000_0005, 32'd0);
      run_md("divu_ovf_pat", MD_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
      run_md("mult_neg", MD_MULT, 32'h8000_0000, 32'hFFFF_FFFF);

      for (int i = 0; i < 4; i++) begin
         run_md("mult_rand", MD_MULT, $urandom, $urandom);
         run_md("multu_rand", MD_MULTU, $urandom, $urandom);
         run_md("div_rand", MD_DIV, $urandom, (i % 2) ? $urandom : -$urandom_range(1, 1000));
         run_md("divu_rand", MD_DIVU, $urandom, $urandom_range(1, 70000));
      end

      // mtlo issued while busy is ignored; result keeps showing the old LO
      exp_q.push_back(model(MD_DIVU, 32'd100, 32'd7));
      issue(MD_DIVU, 32'd100, 32'd7);
      @(negedge clk);
      lp = bus.lo;
      bus.start = 1'b1;
      bus.md_op = MD_MTLO;
      bus.a     = 32'h0000_00AA;
      #1 check("busy_result_old_lo", bus.result, lp);
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done("mtlo_in_busy", DIV_N, 1);

      issue(MD_MTHI, 32'h0000_0055, '0);
      @(negedge clk);
      check("mthi_hi", bus.hi, 32'h0000_0055);
      check("mthi_busy", W'(bus.busy), '0);

      // flush in idle masks a coincident mtlo
      lp = bus.lo;
      @(negedge clk);
      bus.start = 1'b1;
      bus.flush = 1'b1;
      bus.md_op = MD_MTLO;
      bus.a     = 32'hDEAD_BEEF;
      @(posedge clk);
      #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
      @(negedge clk);
      check("idle_flush_lo", bus.lo, lp);

      // flush during the 3rd busy cycle of a mult
      hp = bus.hi;
      lp = bus.lo;
      issue(MD_MULT, 32'd1234, 32'd5678);
      repeat (3) @(negedge clk);
      check("flush3_busy_before", W'(bus.busy), W'(1));
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      @(negedge clk);
      check("flush3_busy", W'(bus.busy), '0);
      check("flush3_hi", bus.hi, hp);
      check("flush3_lo", bus.lo, lp);

      // flush on the exact commit edge
      issue(MD_MULTU, 32'd77, 32'd99);
      repeat (MULT_N) @(negedge clk);
      check("flushc_busy_last", W'(bus.busy), W'(1));
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      @(negedge clk);
      check("flushc_busy", W'(bus.busy), '0);
      check("flushc_hi", bus.hi, hp);
      check("flushc_lo", bus.lo, lp);

      // reset in the middle of a divide
      issue(MD_DIV, 32'd1000, 32'd3);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_busy", W'(bus.busy), '0);
      check("rstmid_hi", bus.hi, '0);
      check("rstmid_lo", bus.lo, '0);
      @(negedge clk) rst_n = 1'b1;

      run_md("post_rst_mult", MD_MULT, 32'hFFFF_FFFE, 32'd3);
      check("scoreboard_drained", W'(exp_q.size()), '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
